// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq
//  Purpose  : Sequential binary-to-BCD converter (shift-add-3 / double
//             dabble), one input bit per cycle. Feeds the per-digit
//             seven-segment decoders: digits[4i+3:4i] -> decoder i 'b',
//             digit_en[i] -> decoder i 'en'.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - synchronous active-low reset
//             in_valid   - in_bin valid
//             in_ready   - converter idle, can accept
//             in_bin     - unsigned binary value (W bits)
//             out_valid  - one-cycle pulse, new digits/digit_en
//             digits     - N BCD nibbles, [3:0] = units
//             digit_en   - per-digit display enable
//  Macro    : BCD_BLANK_EN - leading-zero blanking on digit_en; when not
//             defined digit_en is all ones.
//  Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
   parameter int W = 16,
   parameter int N = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_bin,
   output logic           out_valid,
   output logic [4*N-1:0] digits,
   output logic [N-1:0]   digit_en
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] C_LAST = CW'(W - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

`ifdef BCD_BLANK_EN
   localparam logic [N-1:0] C_EN_RST = N'(1);
`else
   localparam logic [N-1:0] C_EN_RST = '1;
`endif

   logic [1:0]     state_q, state_d;
   logic [W-1:0]   bin_q, bin_d;
   logic [4*N-1:0] bcd_q, bcd_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           out_valid_q, out_valid_d;
   logic [4*N-1:0] digits_q, digits_d;
   logic [N-1:0]   en_q, en_d;

   logic [4*N-1:0] w_adj;
   logic [N-1:0]   w_en;

   // Per-nibble add-3 correction; each nibble is independent (no carries).
   always_comb begin
      logic [3:0] nib;
      w_adj = '0;
      for (int i = 0; i < N; i++) begin
         nib = bcd_q[4*i +: 4];
         w_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
   end

`ifdef BCD_BLANK_EN
   // Walk from the most significant digit down; a digit is lit once any
   // digit at or above it is nonzero. Units always lit.
   always_comb begin
      logic any_nz;
      any_nz = 1'b0;
      w_en   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         any_nz  = any_nz | (|bcd_q[4*i +: 4]);
         w_en[i] = any_nz;
      end
      w_en[0] = 1'b1;
   end
`else
   assign w_en = '1;
`endif

   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      digits_d    = digits_q;
      en_d        = en_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               bin_d   = in_bin;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // Scratch MSB falls off the top; N is sized so it is always 0.
            {bcd_d, bin_d} = {w_adj, bin_q} << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            digits_d    = bcd_q;
            en_d        = w_en;
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bin_q       <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         digits_q    <= '0;
         en_q        <= C_EN_RST;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         digits_q    <= digits_d;
         en_q        <= en_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign digits    = digits_q;
   assign digit_en  = en_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin2bcd_seq
//  Purpose  : Directed + randomized self-checking bench for bin2bcd_seq
//             (W=16, N=5). Honours BCD_BLANK_EN for digit_en expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

   localparam int W = 16;
   localparam int N = 5;
`ifdef BCD_BLANK_EN
   localparam bit c_blank = 1'b1;
`else
   localparam bit c_blank = 1'b0;
`endif
   localparam logic [4:0] c_en_all = 5'h1f;
   localparam logic [4:0] c_en_rst = c_blank ? 5'h01 : 5'h1f;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_bin;
   logic          out_valid;
   logic [19:0]   digits;
   logic [4:0]    digit_en;

   always #5 clk = ~clk;

   bin2bcd_seq #(.W(W), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bin    (in_bin),
      .out_valid (out_valid),
      .digits    (digits),
      .digit_en  (digit_en)
   );

   int          n_chk  = 0;
   int          n_pass = 0;
   logic        mon_en = 1'b0;
   logic [19:0] prev_dig = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Decimal reference by repeated division.
   function automatic logic [19:0] ref_bcd(input int unsigned v);
      logic [19:0] d;
      int unsigned x;
      x = v;
      d = '0;
      for (int i = 0; i < 5; i++) begin
         d[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return d;
   endfunction

   // Enable mask: all digits up to the highest nonzero one (units minimum).
   function automatic logic [4:0] ref_en(input logic [19:0] d);
      int k;
      logic [5:0] t;
      if (!c_blank) return c_en_all;
      k = 0;
      for (int i = 0; i < 5; i++)
         if (d[4*i +: 4] != 4'd0) k = i;
      t = (6'd2 << k) - 6'd1;
      return t[4:0];
   endfunction

   // digits must only move in an out_valid cycle.
   always @(negedge clk) begin
      if (mon_en && !out_valid) chk("stable", {12'd0, digits}, {12'd0, prev_dig});
      prev_dig = digits;
   end

   // Called at a negedge; returns at the negedge where out_valid is seen.
   task automatic convert(input logic [15:0] v, output int lat, output int busy, output bit ok);
      int n;
      n = 0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      in_valid = 1'b1;
      in_bin   = v;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0; busy = 0; ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         lat++;
         if (!in_ready) busy++;
         if (out_valid) ok = 1'b1;
      end
      lat = lat - 1;
   endtask

   int lat, busy, n;
   bit ok, seen;
   logic [15:0] rv;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_bin = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_digits", digits, 0);
      chk("rst_en", digit_en, c_en_rst);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      chk("idle_ready", in_ready, 1);

      // zero
      convert(16'd0, lat, busy, ok);
      chk("zero_done", ok, 1);
      chk("zero_lat", lat, 17);
      chk("zero_digits", digits, 20'h00000);
      chk("zero_en", digit_en, c_blank ? 5'h01 : 5'h1f);

      // full scale
      convert(16'd65535, lat, busy, ok);
      chk("max_done", ok, 1);
      chk("max_lat", lat, 17);
      chk("max_busy", busy, 17);
      chk("max_ready_at_valid", in_ready, 1);
      chk("max_digits", digits, 20'h65535);
      chk("max_en", digit_en, 5'h1f);

      // 1234
      convert(16'd1234, lat, busy, ok);
      chk("k1234_done", ok, 1);
      chk("k1234_digits", digits, 20'h01234);
      chk("k1234_en", digit_en, c_blank ? 5'h0f : 5'h1f);

      // held in_valid across busy window: 9 then 10
      in_valid = 1'b1; in_bin = 16'd9;
      @(posedge clk);
      #1 in_bin = 16'd10;
      @(negedge clk);
      chk("hold_busy", in_ready, 0);
      n = 1;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("hold1_lat", n - 1, 17);
      chk("hold1_digits", digits, 20'h00009);
      chk("hold1_en", digit_en, c_blank ? 5'h01 : 5'h1f);
      chk("hold1_ready", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("hold2_lat", n - 1, 17);
      chk("hold2_digits", digits, 20'h00010);
      chk("hold2_en", digit_en, c_blank ? 5'h03 : 5'h1f);

      // reset mid-conversion
      @(negedge clk);
      in_valid = 1'b1; in_bin = 16'd500;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      mon_en = 1'b0;
      rst_n  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_ready", in_ready, 1);
      chk("abort_valid", out_valid, 0);
      chk("abort_digits", digits, 0);
      chk("abort_en", digit_en, c_en_rst);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_pulse", seen, 0);
      chk("abort_idle", in_ready, 1);
      mon_en = 1'b1;
      convert(16'd42, lat, busy, ok);
      chk("k42_done", ok, 1);
      chk("k42_lat", lat, 17);
      chk("k42_digits", digits, 20'h00042);
      chk("k42_en", digit_en, c_blank ? 5'h03 : 5'h1f);

      // back-to-back random values
      for (int i = 0; i < 1000; i++) begin
         rv = 16'($urandom_range(0, 65535));
         convert(rv, lat, busy, ok);
         chk("rnd_done", ok, 1);
         chk("rnd_digits", digits, ref_bcd(rv));
         chk("rnd_en", digit_en, ref_en(ref_bcd(rv)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
